// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_INPUT,
    ST_OVER
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] colour_onehot(input logic [1:0] colour);
    logic [3:0] one;
    one = 4'b0001;
    return one << colour;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR; colour source for the sequencer.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon game sequencer: grows a random colour sequence, plays it back on
// four LEDs and checks the player's presses against it.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned STEP_CYCLES    = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned MAX_LEN        = 31,
  parameter int unsigned LVL_W          = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       btn,
  output logic [3:0]       led,
  output logic             simon_turn,
  output logic             game_over,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned MAX_SG  = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] STEP_LAST = TMR_W'(STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LEN_MAX   = LVL_W'(MAX_LEN);
  localparam logic [LVL_W-1:0] ONE       = LVL_W'(1);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] len_q, len_d, idx_q, idx_d, level_q, level_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             start_q, simon_turn_q, simon_turn_d, game_over_q, game_over_d;
  logic [3:0]       btn_q, led_q, led_d;
  logic [1:0]       seq_q [MAX_LEN];
  logic             seq_we;

  logic [15:0] lfsr;
  logic [1:0]  colour, show_col;
  logic        start_pe, press, good_press, last_step;
  logic [3:0]  btn_pe;
  logic        unused_lfsr;

  simon_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr)
  );

  assign colour      = lfsr[1:0];
  assign unused_lfsr = ^lfsr[15:2];

  assign start_pe   = start & ~start_q;
  assign btn_pe     = btn & ~btn_q;
  assign press      = |btn_pe;
  // Expected pattern is one-hot, so equality also rejects multi-button presses.
  assign good_press = (btn_pe == colour_onehot(seq_q[idx_q]));
  assign last_step  = (idx_q == len_q - ONE);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    level_d = level_q;
    seq_we  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_pe) begin
          len_d   = '0;
          level_d = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        seq_we  = 1'b1;
        len_d   = len_q + ONE;
        idx_d   = '0;
        timer_d = '0;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (timer_q == STEP_LAST) begin
          timer_d = '0;
          state_d = ST_SHOW_OFF;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_SHOW_OFF: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (last_step) begin
            idx_d   = '0;
            state_d = ST_INPUT;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = ST_SHOW_ON;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_INPUT: begin
        if (press) begin
          if (good_press) begin
            timer_d = '0;
            if (last_step) begin
              level_d = len_q;
              state_d = (len_q == LEN_MAX) ? ST_OVER : ST_ADD;
            end else begin
              idx_d = idx_q + ONE;
            end
          end else begin
            state_d = ST_OVER;
          end
        end else if (timer_q == TO_LAST) begin
          state_d = ST_OVER;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered Moore outputs; the step being written in ADD is bypassed.
  always_comb begin
    show_col     = (seq_we && (len_q == idx_d)) ? colour : seq_q[idx_d];
    simon_turn_d = state_d inside {ST_ADD, ST_SHOW_ON, ST_SHOW_OFF};
    game_over_d  = (state_d == ST_OVER);
    case (state_d)
      ST_SHOW_ON: led_d = colour_onehot(show_col);
      ST_INPUT:   led_d = btn;
      default:    led_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      level_q      <= '0;
      start_q      <= 1'b0;
      btn_q        <= 4'b0000;
      led_q        <= 4'b0000;
      simon_turn_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      level_q      <= level_d;
      start_q      <= start;
      btn_q        <= btn;
      led_q        <= led_d;
      simon_turn_q <= simon_turn_d;
      game_over_q  <= game_over_d;
    end
  end

  always_ff @(posedge clk) begin
    if (seq_we) seq_q[len_q] <= colour;
  end

  assign led        = led_q;
  assign simon_turn = simon_turn_q;
  assign game_over  = game_over_q;
  assign level      = level_q;

endmodule
